// File: rtl/servo_cmd_decoder.sv
// UART command decoder for multi-channel servo positions: parses single-byte
// relative commands and a 'p'+3-digit absolute command, acknowledging each over TX.
module servo_cmd_decoder #(
    parameter int CHANNELS  = 4,
    parameter int POS_WIDTH = 8,
    parameter int STEP      = 20,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = (1 << POS_WIDTH) - 1,
    parameter int POS_INIT  = 1 << (POS_WIDTH - 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            new_rx_data,
    input  logic                            tx_busy,
    output logic [7:0]                      tx_data,
    output logic                            new_tx_data,
    output logic [2:0]                      sel,
    output logic [CHANNELS*POS_WIDTH-1:0]   pos,
    output logic [CHANNELS-1:0]             pos_update
);

    localparam logic [POS_WIDTH-1:0] STEP_V = POS_WIDTH'(STEP);
    localparam logic [POS_WIDTH-1:0] PMIN   = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] PMAX   = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] PINIT  = POS_WIDTH'(POS_INIT);
    localparam logic [7:0]           ACK_OK  = 8'h4B;
    localparam logic [7:0]           ACK_ERR = 8'h3F;

    typedef enum logic [1:0] {CMD, ABS1, ABS2, ABS3} parse_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_t;

    parse_t                 pst;
    tx_t                    tst;
    logic [9:0]             acc;
    logic [9:0]             acc_mac;
    logic                   is_digit;
    logic [7:0]             dval;
    logic [POS_WIDTH-1:0]   cur_pos;
    logic                   wr_en;
    logic [POS_WIDTH-1:0]   wr_val;
    logic                   ack_wr;
    logic [7:0]             ack_val;
    logic                   pend;
    logic [7:0]             ack_byte;

    // '+' is an unsigned sum one bit wider; '-' is signed so an underflow reads as negative.
    function automatic logic [POS_WIDTH-1:0] sat_step(input logic [POS_WIDTH-1:0] p,
                                                      input logic up);
        logic        [POS_WIDTH:0] sum;
        logic signed [POS_WIDTH:0] diff;
        sum  = {1'b0, p} + {1'b0, STEP_V};
        diff = $signed({1'b0, p}) - $signed({1'b0, STEP_V});
        if (up)
            return (sum > {1'b0, PMAX}) ? PMAX : sum[POS_WIDTH-1:0];
        else
            return (diff < $signed({1'b0, PMIN})) ? PMIN : diff[POS_WIDTH-1:0];
    endfunction

    function automatic logic [POS_WIDTH-1:0] sat_abs(input logic [9:0] v);
        if (v > 10'(PMAX))
            return PMAX;
        else if (v < 10'(PMIN))
            return PMIN;
        else
            return POS_WIDTH'(v);
    endfunction

    assign dval     = rx_data - 8'h30;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign acc_mac  = acc * 10'd10 + {6'd0, dval[3:0]};

    always_comb begin
        cur_pos = pos[POS_WIDTH-1:0];
        for (int i = 0; i < CHANNELS; i++)
            if (sel == 3'(i))
                cur_pos = pos[i*POS_WIDTH +: POS_WIDTH];
    end

    // Command decode: what this byte writes and how it is acknowledged.
    always_comb begin
        wr_en   = 1'b0;
        wr_val  = cur_pos;
        ack_wr  = 1'b0;
        ack_val = ACK_ERR;
        if (new_rx_data) begin
            case (pst)
                CMD: begin
                    ack_wr = 1'b1;
                    if (is_digit) begin
                        if (dval < 8'(CHANNELS))
                            ack_val = ACK_OK;
                    end else begin
                        case (rx_data)
                            "+": begin
                                wr_en   = 1'b1;
                                wr_val  = sat_step(cur_pos, 1'b1);
                                ack_val = ACK_OK;
                            end
                            "-": begin
                                wr_en   = 1'b1;
                                wr_val  = sat_step(cur_pos, 1'b0);
                                ack_val = ACK_OK;
                            end
                            "c": begin
                                wr_en   = 1'b1;
                                wr_val  = PINIT;
                                ack_val = ACK_OK;
                            end
                            "p":     ack_wr = 1'b0;
                            default: ack_wr = 1'b1;
                        endcase
                    end
                end
                ABS1, ABS2: ack_wr = !is_digit;
                default: begin
                    ack_wr = 1'b1;
                    if (is_digit) begin
                        wr_en   = 1'b1;
                        wr_val  = sat_abs(acc_mac);
                        ack_val = ACK_OK;
                    end
                end
            endcase
        end
    end

    // Parser state, channel select and position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pst        <= CMD;
            acc        <= '0;
            sel        <= '0;
            pos        <= {CHANNELS{PINIT}};
            pos_update <= '0;
        end else begin
            pos_update <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && sel == 3'(i)) begin
                    pos[i*POS_WIDTH +: POS_WIDTH] <= wr_val;
                    pos_update[i]                 <= 1'b1;
                end
            end
            if (new_rx_data) begin
                case (pst)
                    CMD: begin
                        if (is_digit && dval < 8'(CHANNELS))
                            sel <= dval[2:0];
                        if (rx_data == "p") begin
                            acc <= '0;
                            pst <= ABS1;
                        end
                    end
                    ABS1: begin
                        acc <= acc_mac;
                        pst <= is_digit ? ABS2 : CMD;
                    end
                    ABS2: begin
                        acc <= acc_mac;
                        pst <= is_digit ? ABS3 : CMD;
                    end
                    default: pst <= CMD;
                endcase
            end
        end
    end

    // Ack buffer and TX handshake; the strobe register is set on entry to SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            tst         <= IDLE;
            pend        <= 1'b0;
            ack_byte    <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            case (tst)
                IDLE: begin
                    if (pend && !tx_busy) begin
                        tst         <= SEND;
                        new_tx_data <= 1'b1;
                        tx_data     <= ack_byte;
                    end
                end
                SEND:    tst <= GAP;
                default: tst <= IDLE;
            endcase
            if (ack_wr) begin
                pend     <= 1'b1;
                ack_byte <= ack_val;
            end else if (tst == IDLE && pend && !tx_busy) begin
                pend <= 1'b0;
            end
        end
    end

endmodule
